mult_share_arbiter: RTL and testbench

- Shares one constant-time sequential multiplier (Multiplier_StateBranch) between two requesters.
- Round-robin arbitration with a valid/ready request handshake.
- Sequences the multiplier's rst/start pins and times completion with a fixed-latency counter, because the multiplier has no done output.
- Captures the product and returns it to the granted requester as a one-cycle response pulse.

---
 rtl/mult_share_arbiter.sv | 127 ++++++++++++
 tb/tb_mult_share_arbiter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter sharing one fixed-latency sequential multiplier between two requesters.
// Optional build macro MULT_ARB_ZERO_BYPASS_EN short-circuits zero-operand requests to an immediate zero result.
module mult_share_arbiter #(
  parameter int NUM_BITS     = 7,
  parameter int MULT_LATENCY = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req0_valid,
  input  logic [NUM_BITS-1:0]     req0_a,
  input  logic [NUM_BITS-1:0]     req0_b,
  output logic                    req0_ready,
  input  logic                    req1_valid,
  input  logic [NUM_BITS-1:0]     req1_a,
  input  logic [NUM_BITS-1:0]     req1_b,
  output logic                    req1_ready,
  output logic                    resp0_valid,
  output logic                    resp1_valid,
  output logic [2*NUM_BITS-1:0]   resp_product,
  output logic                    mult_rst,
  output logic                    mult_start,
  output logic [NUM_BITS-1:0]     mult_multiplier,
  output logic [NUM_BITS-1:0]     mult_multiplicand,
  input  logic [2*NUM_BITS-1:0]   mult_product
);

  localparam int CW = (MULT_LATENCY < 2) ? 1 : $clog2(MULT_LATENCY);

  typedef enum logic [2:0] {IDLE, CLR, LAUNCH, WAIT, DONE} state_t;

  state_t          state, state_nxt;
  logic            rr_ptr;
  logic            owner;
  logic [CW-1:0]   counter;
  logic            win;
  logic            accept;
  logic [NUM_BITS-1:0] win_a, win_b;
`ifdef MULT_ARB_ZERO_BYPASS_EN
  logic            bypass;
  logic            zero_op;
`endif

  // Handshake: a transfer happens on the rising edge where reqN_valid and
  // reqN_ready are both high; ready is combinational and only ever offered to
  // the arbitration winner while IDLE. Requesters hold valid/operands until then.
  always_comb begin
    win    = (req0_valid && req1_valid) ? rr_ptr : req1_valid;
    win_a  = win ? req1_a : req0_a;
    win_b  = win ? req1_b : req0_b;
    accept = (state == IDLE) && !rst && (req0_valid || req1_valid);
    req0_ready = accept && !win;
    req1_ready = accept && win;
  end

`ifdef MULT_ARB_ZERO_BYPASS_EN
  assign zero_op = (win_a == '0) || (win_b == '0);
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
`ifdef MULT_ARB_ZERO_BYPASS_EN
          state_nxt = zero_op ? DONE : CLR;
`else
          state_nxt = CLR;
`endif
        end
      end
      CLR:    state_nxt = LAUNCH;
      LAUNCH: state_nxt = WAIT;
      WAIT:   if (counter == '0) state_nxt = DONE;
      DONE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign mult_rst   = rst || (state == CLR);
  assign mult_start = (state == LAUNCH);

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      rr_ptr            <= 1'b0;
      owner             <= 1'b0;
      counter           <= '0;
      mult_multiplier   <= '0;
      mult_multiplicand <= '0;
      resp_product      <= '0;
      resp0_valid       <= 1'b0;
      resp1_valid       <= 1'b0;
`ifdef MULT_ARB_ZERO_BYPASS_EN
      bypass            <= 1'b0;
`endif
    end else begin
      state       <= state_nxt;
      resp0_valid <= 1'b0;
      resp1_valid <= 1'b0;
      if (accept) begin
        mult_multiplier   <= win_a;
        mult_multiplicand <= win_b;
        owner             <= win;
        rr_ptr            <= !win;
`ifdef MULT_ARB_ZERO_BYPASS_EN
        bypass            <= zero_op;
`endif
      end
      if (state == LAUNCH) begin
        counter <= CW'(MULT_LATENCY - 1);
      end else if (state == WAIT && counter != '0) begin
        counter <= counter - 1'b1;
      end
      // The response is registered, so it appears the cycle after DONE.
      if (state == DONE) begin
`ifdef MULT_ARB_ZERO_BYPASS_EN
        resp_product <= bypass ? '0 : mult_product;
`else
        resp_product <= mult_product;
`endif
        resp0_valid  <= !owner;
        resp1_valid  <= owner;
      end
    end
  end

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Self-checking bench for mult_share_arbiter: behavioural multiplier, arbitration/response
// reference model with an expected queue, directed plus randomized steps.
module tb_mult_share_arbiter;
  localparam int N = 7;
  localparam int L = 16;
  localparam int W = 2 * N;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0_valid, req1_valid;
  logic [N-1:0] req0_a, req0_b, req1_a, req1_b;
  logic         req0_ready, req1_ready;
  logic         resp0_valid, resp1_valid;
  logic [W-1:0] resp_product;
  logic         mult_rst, mult_start;
  logic [N-1:0] mult_multiplier, mult_multiplicand;
  logic [W-1:0] mult_product;

  mult_share_arbiter #(.NUM_BITS(N), .MULT_LATENCY(L)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
    .resp0_valid(resp0_valid), .resp1_valid(resp1_valid), .resp_product(resp_product),
    .mult_rst(mult_rst), .mult_start(mult_start),
    .mult_multiplier(mult_multiplier), .mult_multiplicand(mult_multiplicand),
    .mult_product(mult_product)
  );

  // clock / reset block
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  // Multiplier stand-in: garbage until L edges after the start cycle, then the
  // product of whatever operands are presented at that moment.
  int m_cnt = 0;
  always @(posedge clk) begin
    if (mult_rst) begin
      mult_product <= '0;
      m_cnt        <= 0;
    end else if (mult_start) begin
      mult_product <= {W{1'b1}};
      m_cnt        <= L - 1;
    end else if (m_cnt > 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) mult_product <= W'(mult_multiplier) * W'(mult_multiplicand);
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // scoreboard / reference model
  logic [W-1:0] exp_q[$];
  int           exp_own_q[$];
  int           exp_cyc_q[$];
  int           acc_cyc[$];
  int           acc_own[$];
  int           n_resp = 0;
  int           n_start = 0;
  logic         model_rr = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete(); exp_own_q.delete(); exp_cyc_q.delete();
      model_rr = 1'b0;
    end else begin
      if (mult_start) n_start++;
      if (resp0_valid || resp1_valid) begin
        n_resp++;
        check("resp_onehot", resp0_valid & resp1_valid, 0);
        check("resp_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          check("resp_owner", resp1_valid, exp_own_q[0]);
          check("resp_product", resp_product, exp_q[0]);
          check("resp_cycle", cyc, exp_cyc_q[0]);
          void'(exp_q.pop_front()); void'(exp_own_q.pop_front()); void'(exp_cyc_q.pop_front());
        end
      end
      if (req0_ready || req1_ready) begin
        int w;
        logic [N-1:0] a, b;
        int lat;
        w = (req0_valid && req1_valid) ? int'(model_rr) : int'(req1_valid);
        check("grant_owner", req1_ready, w);
        check("grant_onehot", req0_ready & req1_ready, 0);
        check("grant_valid", (req0_ready & req0_valid) | (req1_ready & req1_valid), 1);
        check("grant_while_busy", exp_q.size(), 0);
        a = req1_ready ? req1_a : req0_a;
        b = req1_ready ? req1_b : req0_b;
        lat = L + 3;
`ifdef MULT_ARB_ZERO_BYPASS_EN
        if (a == 0 || b == 0) lat = 1;
`endif
        exp_q.push_back(W'(a) * W'(b));
        exp_own_q.push_back(int'(req1_ready));
        exp_cyc_q.push_back(cyc + 1 + lat);
        acc_cyc.push_back(cyc + 1);
        acc_own.push_back(int'(req1_ready));
        model_rr = !req1_ready;
      end
    end
  end

  // driver tasks (called just after a rising edge)
  task automatic do_reset();
    req0_valid = 0; req1_valid = 0;
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
  endtask

  task automatic drive(input bit v0, input logic [N-1:0] a0, input logic [N-1:0] b0,
                       input bit v1, input logic [N-1:0] a1, input logic [N-1:0] b1);
    int t = 0;
    bit d0, d1;
    req0_valid = v0; req0_a = a0; req0_b = b0;
    req1_valid = v1; req1_a = a1; req1_b = b1;
    while ((req0_valid || req1_valid) && t < 200) begin
      @(negedge clk);
      d0 = req0_valid && req0_ready;
      d1 = req1_valid && req1_ready;
      @(posedge clk); #1;
      if (d0) req0_valid = 0;
      if (d1) req1_valid = 0;
      t++;
    end
    check("drive_timeout", t < 200, 1);
    req0_valid = 0; req1_valid = 0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while (exp_q.size() > 0 && t < 200) begin
      @(posedge clk); t++;
    end
    check("idle_timeout", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    int base, ra, rb, s0, r0;
    req0_valid = 0; req1_valid = 0;
    req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;
    rst = 1;

    // reset state, with a request already pending
    req0_valid = 1; req0_a = 15; req0_b = 15;
    repeat (3) @(posedge clk);
    #1;
    check("rst_mult_rst", mult_rst, 1);
    check("rst_ready0", req0_ready, 0);
    check("rst_resp0", resp0_valid, 0);
    check("rst_resp1", resp1_valid, 0);
    check("rst_product", resp_product, 0);
    check("rst_start", mult_start, 0);
    check("rst_operand", mult_multiplier, 0);

    // 15x15 from requester 0, ready in the first cycle out of reset
    rst = 0; #1;
    check("first_ready0", req0_ready, 1);
    check("first_mult_rst", mult_rst, 0);
    drive(1, 15, 15, 0, 0, 0);
    wait_idle();
    repeat (3) @(posedge clk);
    #1 check("product_held", resp_product, 225);

    // simultaneous requests after reset: requester 0 first, then 1
    do_reset();
    base = acc_cyc.size();
    drive(1, 92, 75, 1, 42, 78);
    wait_idle();
    check("pair_count", acc_cyc.size() - base, 2);
    if (acc_cyc.size() - base == 2) begin
      check("pair_first", acc_own[base], 0);
      check("pair_second", acc_own[base+1], 1);
      check("pair_gap", acc_cyc[base+1] - acc_cyc[base], L + 4);
    end
    check("pair_last_product", resp_product, 3276);

    // both requesters continuously valid for four operations
    do_reset();
    base = acc_cyc.size();
    req0_valid = 1; req0_a = N'($urandom_range(1, 127)); req0_b = N'($urandom_range(1, 127));
    req1_valid = 1; req1_a = N'($urandom_range(1, 127)); req1_b = N'($urandom_range(1, 127));
    for (int t = 0; t < 400 && acc_cyc.size() - base < 4; t++) begin
      bit d0, d1;
      @(negedge clk);
      d0 = req0_valid && req0_ready;
      d1 = req1_valid && req1_ready;
      @(posedge clk); #1;
      if (d0) begin req0_a = N'($urandom_range(1, 127)); req0_b = N'($urandom_range(1, 127)); end
      if (d1) begin req1_a = N'($urandom_range(1, 127)); req1_b = N'($urandom_range(1, 127)); end
    end
    req0_valid = 0; req1_valid = 0;
    wait_idle();
    check("cont_count", acc_cyc.size() - base, 4);
    if (acc_cyc.size() - base == 4) begin
      for (int i = 0; i < 4; i++) check("cont_owner", acc_own[base+i], i % 2);
      for (int i = 1; i < 4; i++) check("cont_gap", acc_cyc[base+i] - acc_cyc[base+i-1], L + 4);
    end

    // reset while WAITing abandons the operation
    drive(0, 0, 0, 1, 127, 127);
    repeat (6) @(posedge clk);
    r0 = n_resp;
    #1 rst = 1;
    @(negedge clk);
    check("midrst_mult_rst", mult_rst, 1);
    @(posedge clk);
    @(negedge clk);
    check("midrst_mult_rst2", mult_rst, 1);
    @(posedge clk); #1 rst = 0;
    repeat (L + 8) @(posedge clk);
    #1 check("midrst_no_resp", n_resp, r0);
    base = acc_cyc.size();
    ra = $urandom_range(1, 127); rb = $urandom_range(1, 127);
    drive(1, N'(ra), N'(rb), 1, 1, 2);
    wait_idle();
    check("midrst_rr0", acc_own[base], 0);
    check("midrst_last_product", resp_product, 2);

    // zero operand
    s0 = n_start;
    drive(1, 0, 12, 0, 0, 0);
    wait_idle();
    check("zero_product", resp_product, 0);
`ifdef MULT_ARB_ZERO_BYPASS_EN
    check("zero_no_start", n_start - s0, 0);
`else
    check("zero_one_start", n_start - s0, 1);
`endif

    // valid dropped before ready while busy
    base = acc_cyc.size();
    r0 = n_resp;
    drive(1, N'($urandom_range(1, 127)), N'($urandom_range(1, 127)), 0, 0, 0);
    repeat (3) @(posedge clk);
    #1 req1_valid = 1; req1_a = 9; req1_b = 9;
    repeat (4) @(posedge clk);
    #1 req1_valid = 0;
    wait_idle();
    check("drop_accepts", acc_cyc.size() - base, 1);
    check("drop_resps", n_resp - r0, 1);
    base = acc_cyc.size();
    drive(1, 3, 5, 1, 7, 11);
    wait_idle();
    check("drop_rr_kept", acc_own[base], 1);

    // randomized mix
    for (int i = 0; i < 8; i++) begin
      int m;
      m = $urandom_range(1, 3);
      drive(m[0], N'($urandom_range(0, 127)), N'($urandom_range(0, 127)),
            m[1], N'($urandom_range(0, 127)), N'($urandom_range(0, 127)));
      wait_idle();
    end

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end
endmodule
